// File: rtl/fa_mc_nb.sv
// rtl/fa_mc_nb.sv - digit-serial multi-cycle adder/subtractor with valid/ready handshakes (optional accumulator: FA_MC_ACC_EN)
module fa_mc_nb #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dataA,
  input  logic [WIDTH-1:0] i_dataB,
  input  logic             i_cin,
  input  logic             i_sub,
`ifdef FA_MC_ACC_EN
  input  logic             i_acc,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_src;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] s_dig;
  logic             dig_cout;
  logic             dig_ovf;

  // Operand A source: the fresh input, or the held result when accumulating
  always_comb begin
`ifdef FA_MC_ACC_EN
    a_src = i_acc ? o_sum : i_dataA;
`else
    a_src = i_dataA;
`endif
  end

  // Pick the digit of each captured operand addressed by the digit counter
  always_comb begin
    a_dig = a_reg[int'(cnt) * DIGIT +: DIGIT];
    b_dig = b_reg[int'(cnt) * DIGIT +: DIGIT];
  end

  // Single DIGIT-bit ripple full-adder chain seeded by the carry register
  always_comb begin : ripple
    logic c;
    c     = carry;
    s_dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s_dig[i] = a_dig[i] ^ b_dig[i] ^ c;
      c        = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
    end
    dig_cout = c;
  end

  // Signed overflow only meaningful on the top digit: like-signed operands, differently-signed sum
  always_comb begin
    dig_ovf = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (s_dig[DIGIT-1] != a_dig[DIGIT-1]);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg   <= a_src;
            // Subtraction is A + ~B + 1; carry-in input is ignored in that mode
            b_reg   <= i_sub ? ~i_dataB : i_dataB;
            carry   <= i_sub ? 1'b1 : i_cin;
            cnt     <= '0;
            o_ready <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          o_sum[int'(cnt) * DIGIT +: DIGIT] <= s_dig;
          carry <= dig_cout;
          if (cnt == LAST) begin
            o_cout  <= dig_cout;
            o_ovf   <= dig_ovf;
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Result handshake only; a pending request waits until IDLE
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_mc_nb.sv
// tb/tb_fa_mc_nb.sv - self-checking bench for fa_mc_nb against an arithmetic reference model
module tb_fa_mc_nb;

  localparam int W    = 32;
  localparam int D    = 8;
  localparam int NDIG = W / D;
  localparam longint MAXS = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint MINS = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] da = '0;
  logic [W-1:0] db = '0;
  logic         cin_s = 1'b0;
  logic         sub_s = 1'b0;
`ifdef FA_MC_ACC_EN
  logic         acc = 1'b0;
`endif
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fa_mc_nb #(.WIDTH(W), .DIGIT(D)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (o_ready),
    .i_dataA (da),
    .i_dataB (db),
    .i_cin   (cin_s),
    .i_sub   (sub_s),
`ifdef FA_MC_ACC_EN
    .i_acc   (acc),
`endif
    .o_valid (o_valid),
    .i_ready (ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  // Reference: plain integer arithmetic on the whole word
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, output logic [W-1:0] s, output logic c,
                                output logic v);
    longint ra;
    logic [W:0] wide;
    if (sub) begin
      s  = a - b;
      c  = (a >= b);
      ra = longint'($signed(a)) - longint'($signed(b));
    end else begin
      wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      s    = wide[W-1:0];
      c    = wide[W];
      ra   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    v = (ra > MAXS) || (ra < MINS);
  endfunction

  // Issue one operation, wait (bounded) for the result, then consume it
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output int lat, output logic [W-1:0] s,
                        output logic c, output logic v, output logic rdy_busy,
                        output logic v_after, output logic r_after);
    @(negedge clk);
    valid = 1'b1; da = a; db = b; cin_s = cin; sub_s = sub; ready = 1'b0;
    rdy_busy = 1'b0;
    lat = 0;
    @(negedge clk);
    valid = 1'b0;
    while (!o_valid && lat < 4 * NDIG + 8) begin
      if (o_ready) rdy_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    s = o_sum; c = o_cout; v = o_ovf;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    v_after = o_valid;
    r_after = o_ready;
  endtask

  task automatic test_reset();
    @(negedge clk);
    valid = 1'b1; da = 32'h7FFF_FFFF; db = 32'h1; cin_s = 1'b0; sub_s = 1'b0; ready = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    repeat (NDIG + 1) @(negedge clk);
    n_vec++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", o_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_vec++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_vec++;
    if (o_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", o_sum); end
    n_vec++;
    if (o_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", o_cout); end
    n_vec++;
    if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_ovf); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] es;
    logic         ec;
    logic         ev;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[5];
    int lat;
    logic [W-1:0] s;
    logic c, v, rb, va, ra;
    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat, s, c, v, rb, va, ra);
      n_vec++;
      if (lat != NDIG) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NDIG); end
      n_vec++;
      if (s !== tbl[i].es) begin n_fail++; $display("FAIL dir%0d_sum: got %h want %h", i, s, tbl[i].es); end
      n_vec++;
      if (c !== tbl[i].ec) begin n_fail++; $display("FAIL dir%0d_cout: got %b want %b", i, c, tbl[i].ec); end
      n_vec++;
      if (v !== tbl[i].ev) begin n_fail++; $display("FAIL dir%0d_ovf: got %b want %b", i, v, tbl[i].ev); end
      n_vec++;
      if (rb !== 1'b0) begin n_fail++; $display("FAIL dir%0d_ready_busy: got %b want 0", i, rb); end
      n_vec++;
      if (va !== 1'b0 || ra !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_after_accept: valid %b ready %b want 0 1", i, va, ra);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b, s, es;
    logic cin, sub, c, v, rb, va, ra, ec, ev;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h0000_0000;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      model(a, b, cin, sub, es, ec, ev);
      run_op(a, b, cin, sub, lat, s, c, v, rb, va, ra);
      n_vec++;
      if (s !== es || c !== ec || v !== ev || lat != NDIG) begin
        n_fail++;
        $display("FAIL rnd%0d: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d want sum=%h cout=%b ovf=%b lat=%0d",
                 i, a, b, cin, sub, s, c, v, lat, es, ec, ev, NDIG);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] es1, es2;
    logic ec1, ev1, ec2, ev2;
    int lat;
    model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, es1, ec1, ev1);
    model(32'h0000_000A, 32'h0000_0005, 1'b0, 1'b1, es2, ec2, ev2);
    @(negedge clk);
    valid = 1'b1; da = 32'h1234_5678; db = 32'h1111_1111; cin_s = 1'b0; sub_s = 1'b0; ready = 1'b0;
    @(negedge clk);
    da = 32'h0000_000A; db = 32'h0000_0005; sub_s = 1'b1;
    lat = 0;
    while (!o_valid && lat < 4 * NDIG + 8) begin @(negedge clk); lat++; end
    n_vec++;
    if (o_valid !== 1'b1 || o_sum !== es1) begin
      n_fail++; $display("FAIL bp_first_result: valid %b sum %h want 1 %h", o_valid, o_sum, es1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (o_valid !== 1'b1 || o_sum !== es1 || o_cout !== ec1 || o_ovf !== ev1 || o_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid %b sum %h cout %b ovf %b ready %b want 1 %h %b %b 0",
                 i, o_valid, o_sum, o_cout, o_ovf, o_ready, es1, ec1, ev1);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid %b ready %b want 0 1", o_valid, o_ready);
    end
    @(negedge clk);
    valid = 1'b0;
    n_vec++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: ready %b want 0", o_ready); end
    lat = 0;
    while (!o_valid && lat < 4 * NDIG + 8) begin @(negedge clk); lat++; end
    n_vec++;
    if (lat != NDIG || o_sum !== es2 || o_cout !== ec2 || o_ovf !== ev2) begin
      n_fail++;
      $display("FAIL bp_second_result: lat %0d sum %h cout %b ovf %b want %0d %h %b %b",
               lat, o_sum, o_cout, o_ovf, NDIG, es2, ec2, ev2);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    logic seen;
    int lat;
    logic [W-1:0] s, es;
    logic c, v, rb, va, ra, ec, ev;
    @(negedge clk);
    valid = 1'b1; da = 32'hDEAD_BEEF; db = 32'h0BAD_F00D; cin_s = 1'b1; sub_s = 1'b0; ready = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sum !== '0) begin
      n_fail++; $display("FAIL busy_reset: valid %b ready %b sum %h want 0 1 0", o_valid, o_ready, o_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2 * NDIG + 4; i++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    ready = 1'b0;
    n_vec++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL busy_reset_no_valid: got pulse %b want 0", seen); end
    model(32'h0000_1000, 32'h0000_0FFF, 1'b0, 1'b1, es, ec, ev);
    run_op(32'h0000_1000, 32'h0000_0FFF, 1'b0, 1'b1, lat, s, c, v, rb, va, ra);
    n_vec++;
    if (s !== es || c !== ec || v !== ev) begin
      n_fail++; $display("FAIL post_reset_op: got %h %b %b want %h %b %b", s, c, v, es, ec, ev);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, es;
    logic ec, ev, prev;
    int last_t, rises;
    a = $urandom; b = $urandom;
    model(a, b, 1'b0, 1'b0, es, ec, ev);
    @(negedge clk);
    valid = 1'b1; ready = 1'b1; da = a; db = b; cin_s = 1'b0; sub_s = 1'b0;
    prev = 1'b0; last_t = -1; rises = 0;
    for (int t = 0; t < 6 * (NDIG + 2); t++) begin
      @(negedge clk);
      if (o_valid && !prev) begin
        rises++;
        n_vec++;
        if (o_sum !== es || o_cout !== ec || o_ovf !== ev) begin
          n_fail++; $display("FAIL b2b_result: got %h %b %b want %h %b %b", o_sum, o_cout, o_ovf, es, ec, ev);
        end
        if (last_t >= 0) begin
          n_vec++;
          if (t - last_t != NDIG + 2) begin
            n_fail++; $display("FAIL b2b_interval: got %0d want %0d", t - last_t, NDIG + 2);
          end
        end
        last_t = t;
      end
      prev = o_valid;
    end
    n_vec++;
    if (rises < 5) begin n_fail++; $display("FAIL b2b_count: got %0d want >= 5", rises); end
    valid = 1'b0;
    repeat (NDIG + 3) @(negedge clk);
    ready = 1'b0;
  endtask

`ifdef FA_MC_ACC_EN
  task automatic test_acc();
    int lat;
    logic [W-1:0] s, total;
    logic c, v, rb, va, ra;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc = 1'b1;
    total = '0;
    for (int i = 0; i < 3; i++) begin
      total = total + 32'd10;
      run_op(32'hFFFF_0000, 32'd10, 1'b0, 1'b0, lat, s, c, v, rb, va, ra);
      n_vec++;
      if (s !== total) begin n_fail++; $display("FAIL acc%0d_sum: got %h want %h", i, s, total); end
    end
    acc = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
`ifdef FA_MC_ACC_EN
    test_acc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_mc_nb.md
Name: fa_mc_nb

Overview:
- Parametrised digit-serial multi-cycle adder/subtractor; next generation of the fixed-width ripple full-adder family.
- Adds WIDTH-bit operands one DIGIT-wide slice per clock through a single DIGIT-bit ripple full-adder chain, with the carry held in a register between slices.
- Trades latency for area and uses valid/ready handshakes on input and output.
- Used where a full-width combinational adder does not meet area or timing, e.g. the ones-counter accumulation path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 8, bits added per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  operand request.
- o_ready  output  1  block can accept operands (high only in IDLE).
- i_dataA  input  WIDTH  operand A.
- i_dataB  input  WIDTH  operand B.
- i_cin  input  1  carry-in (add mode only).
- i_sub  input  1  1 = A - B, 0 = A + B + i_cin.
- o_valid  output  1  result available.
- i_ready  input  1  consumer accepts result.
- o_sum  output  WIDTH  result.
- o_cout  output  1  carry out of MSB (sub mode: 1 = no borrow).
- o_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (asynchronous, i_rst=1): state IDLE, o_ready=1, o_valid=0, o_sum=0, o_cout=0, o_ovf=0, digit counter 0, carry register 0.
- NDIG = WIDTH/DIGIT. Counter width = clog2(NDIG), minimum 1.
- IDLE:
  - o_ready=1.
  - On i_valid=1: capture A; capture B' = i_sub ? ~i_dataB : i_dataB; carry register = i_sub ? 1 : i_cin (i_cin ignored in sub mode).
  - Clear counter, go to BUSY.
- BUSY:
  - o_ready=0; i_valid ignored.
  - Each cycle k (0..NDIG-1): slice k of o_sum and carry register <= A[k] + B'[k] + carry.
  - After slice NDIG-1: latch o_cout = final carry; o_ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]); go to DONE.
- DONE:
  - o_valid=1; o_sum, o_cout and o_ovf held stable until accepted.
  - On i_ready=1: o_valid deasserts next cycle, return to IDLE.
  - No back-to-back accept in the same cycle; o_ready rises the cycle after DONE exits.
- Latency: operands accepted on edge 0; o_valid high after edge NDIG (NDIG=1 gives one BUSY cycle). Throughput: one operation per NDIG+2 cycles minimum.
- o_sum contents during BUSY are partial and not guaranteed; only valid when o_valid=1.
- Wrap-around: results are modulo 2^WIDTH; carry and overflow are reported only through o_cout and o_ovf.
- i_rst asserted in any state, including mid-BUSY: immediate return to reset values; the in-flight operation is discarded with no o_valid pulse.
- i_valid and i_ready both high in DONE: only the result handshake completes; the new request is not taken until IDLE.

Optional Feature:
- Macro FA_MC_ACC_EN. When defined:
  - Extra port i_acc (input, 1).
  - If i_acc=1 at operand capture, operand A is the previous o_sum register instead of i_dataA, giving a running accumulator.
  - Reset clears the accumulated value to 0.
- When undefined: i_acc is absent and A is always i_dataA.

Test Plan:
- WIDTH=32, DIGIT=8. Pulse i_rst mid-cycle -> o_ready=1, o_valid=0, o_sum=0, o_cout=0, o_ovf=0 asynchronously.
- Add A=0x000000FF, B=0x00000001, cin=0, i_ready=1 -> o_valid high exactly 4 cycles after accept; o_sum=0x00000100, cout=0, ovf=0 (carry crosses a digit boundary).
- Add A=0xFFFFFFFF, B=0, cin=1 -> o_sum=0, cout=1, ovf=0. Add A=0x7FFFFFFF, B=1 -> o_sum=0x80000000, ovf=1.
- Sub A=5, B=7 -> o_sum=0xFFFFFFFE, cout=0, ovf=0. Sub A=0x80000000, B=1 -> o_sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: i_ready=0 for 3 cycles in DONE while i_valid=1 with new operands -> o_valid and o_sum held, o_ready=0, new operands not captured; release i_ready -> IDLE, then the next request is accepted.
- Assert i_rst during BUSY at digit 2 -> IDLE, no o_valid pulse. With FA_MC_ACC_EN: three accumulating adds of 10 (i_acc=1) after reset -> o_sum=30.
